// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - copies the program ROM image into instruction memory, then releases the core
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (running sum of accepted write data on checksum)
module prog_loader #(
    parameter int ROM_DEPTH = 256,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROM_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] idx;
    logic              sync1;
    logic              sync2;
    logic              sync3;
    logic              start_pulse;
    logic              load_begin;
    logic              write_accept;

    // Two-flop synchronizer for the button level plus a history flop for edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= start;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign start_pulse  = sync2 & ~sync3;
    // A start only counts when no load is running; mid-load pulses are dropped
    assign load_begin   = start_pulse & ((state == IDLE) | (state == DONE));
    assign write_accept = (state == WRITE) & mem_ready;
    assign rom_addr     = idx;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: FETCH -> LATCH -> WRITE per word, WRITE waits on mem_ready
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_pulse) next_state = FETCH;
            FETCH:   next_state = LATCH;
            LATCH:   next_state = WRITE;
            WRITE: begin
                if (mem_ready) begin
                    next_state = (idx == LAST_IDX) ? DONE : FETCH;
                end
            end
            DONE:    if (start_pulse) next_state = FETCH;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: write strobe only in WRITE, busy across the whole per-word loop
    always_comb begin
        mem_we = 1'b0;
        busy   = 1'b0;
        case (state)
            FETCH, LATCH: busy = 1'b1;
            WRITE: begin
                busy   = 1'b1;
                mem_we = 1'b1;
            end
            default: ;
        endcase
    end

    // Word index, write-port registers and registered run/done flags
    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_run   <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (load_begin) begin
                idx <= '0;
            end else if (write_accept && (idx != LAST_IDX)) begin
                idx <= idx + ADDR_W'(1);
            end
            // ROM data for idx arrives during LATCH; capture it with its address
            if (state == LATCH) begin
                mem_wdata <= rom_data;
                mem_addr  <= idx;
            end
            cpu_run <= (next_state == DONE);
            done    <= (next_state == DONE);
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running sum of every accepted write, restarted with each new load
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= '0;
        end else if (load_begin) begin
            checksum <= '0;
        end else if (write_accept) begin
            checksum <= checksum + mem_wdata;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule
